// File: rtl/motor_reg_pkg.sv
// motor_reg_pkg: address map, field positions and widths shared by the motor register bank
package motor_reg_pkg;
    localparam int ANGLE_W = 12;
    localparam int ID_A = 0;
    localparam int BCAST_A = 1;
    localparam int IRQ_EN_A = 2;
    localparam int IRQ_PEND_A = 3;
    localparam int CURR_HI_A = 4;
    typedef enum logic [1:0] {OFF_CTRL, OFF_TARG, OFF_STAT, OFF_CURR} chan_off_e;
    localparam int CTRL_BRAKE = 7;
    localparam int CTRL_EN = 6;
    localparam int CTRL_DIR = 5;
    localparam int ST_FAULT = 7;
    localparam int CMD_UPD = 5;
    localparam int CMD_ABT = 4;
endpackage

// File: rtl/motor_reg_chan.sv
// motor_reg_chan: one channel's control, staged/committed target, sticky status and command pulses
module motor_reg_chan
    import motor_reg_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               sel,
    input  logic               bcast,
    input  logic               write_en,
    input  logic [1:0]         off,
    input  logic [7:0]         wr_data,
    input  logic               fault,
    input  logic               startup_fail,
    input  logic               angle_done,
    input  logic [ANGLE_W-1:0] current_angle,
    output logic               brake,
    output logic               enable,
    output logic               direction,
    output logic [ANGLE_W-1:0] target_angle,
    output logic               update_angle,
    output logic               abort_angle,
    output logic               pend,
    output logic [7:0]         rd_mux
);
    logic [7:0] ctrl, targ_lo;
    logic [2:0] sticky, set;
    logic ctrl_wr, targ_wr, stat_wr, cmd_wr;
    assign ctrl_wr = bcast || (sel && write_en && off == OFF_CTRL);
    assign targ_wr = sel && write_en && off == OFF_TARG;
    assign stat_wr = sel && write_en && off == OFF_STAT;
    assign cmd_wr = sel && write_en && off == OFF_CURR;
    assign set = {fault, startup_fail, angle_done};
    assign brake = ctrl[CTRL_BRAKE];
    assign enable = ctrl[CTRL_EN];
    assign direction = ctrl[CTRL_DIR];
    assign pend = |sticky;
    assign rd_mux = !sel ? 8'h00 :
                    off == OFF_CTRL ? ctrl :
                    off == OFF_TARG ? targ_lo :
                    off == OFF_STAT ? {sticky, 5'b0} : current_angle[7:0];
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            {ctrl, targ_lo, target_angle, sticky, update_angle, abort_angle} <= '0;
        end else begin
            if (ctrl_wr) ctrl <= {wr_data[7:5], 1'b0, wr_data[3:0]};
            if (targ_wr) begin
                targ_lo <= wr_data;
                target_angle <= {ctrl[3:0], wr_data};
            end
            // set is ORed after the clear so a simultaneous event survives
            sticky <= (stat_wr ? sticky & ~wr_data[ST_FAULT -: 3] : sticky) | set;
            update_angle <= cmd_wr && wr_data[CMD_UPD] && !wr_data[CMD_ABT];
            abort_angle <= cmd_wr && wr_data[CMD_ABT];
        end
    end
endmodule

// File: rtl/motor_reg_bank.sv
// motor_reg_bank: host byte-bus register bank for NUM_CH motor channels with registered reads and irq
module motor_reg_bank
    import motor_reg_pkg::*;
#(
    parameter int         NUM_CH  = 4,
    parameter int         ADDR_W  = 6,
    parameter int         CH_BASE = 8,
    parameter logic [7:0] VERSION = 8'h21
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [ADDR_W-1:0]         address,
    input  logic                      write_en,
    input  logic [7:0]                wr_data,
    input  logic                      read_en,
    output logic [7:0]                rd_data,
    output logic                      rd_valid,
    output logic                      addr_err,
    input  logic [NUM_CH-1:0]         fault,
    input  logic [NUM_CH-1:0]         startup_fail,
    input  logic [NUM_CH-1:0]         angle_done,
    input  logic [ANGLE_W*NUM_CH-1:0] current_angle,
    output logic [NUM_CH-1:0]         brake,
    output logic [NUM_CH-1:0]         enable,
    output logic [NUM_CH-1:0]         direction,
    output logic [ANGLE_W*NUM_CH-1:0] target_angle,
    output logic [NUM_CH-1:0]         update_angle,
    output logic [NUM_CH-1:0]         abort_angle,
    output logic                      irq
);
    localparam int EW = NUM_CH < 8 ? NUM_CH : 8;
    localparam logic [ADDR_W:0] CH_END = (ADDR_W+1)'(CH_BASE + 4*NUM_CH);
    logic [ADDR_W-1:0] rel;
    logic in_ch, mapped, bcast_wr, curr_rd;
    logic [NUM_CH-1:0] sel, pend, last_sel;
    logic [7:0] ch_rd [NUM_CH];
    logic [7:0] ch_or, rd_next;
    logic [3:0] hi_or, shadow_hi;
    logic [EW-1:0] irq_en;
    assign rel = address - ADDR_W'(CH_BASE);
    assign in_ch = address >= ADDR_W'(CH_BASE) && {1'b0, address} < CH_END;
    assign mapped = in_ch || address <= ADDR_W'(CURR_HI_A);
    assign bcast_wr = write_en && address == ADDR_W'(BCAST_A);
    assign curr_rd = read_en && in_ch && rel[1:0] == OFF_CURR;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign sel[i] = in_ch && rel[ADDR_W-1:2] == (ADDR_W-2)'(i);
        motor_reg_chan u_ch (
            .clock(clock), .reset_n(reset_n), .sel(sel[i]), .bcast(bcast_wr),
            .write_en(write_en), .off(rel[1:0]), .wr_data(wr_data),
            .fault(fault[i]), .startup_fail(startup_fail[i]), .angle_done(angle_done[i]),
            .current_angle(current_angle[ANGLE_W*i +: ANGLE_W]),
            .brake(brake[i]), .enable(enable[i]), .direction(direction[i]),
            .target_angle(target_angle[ANGLE_W*i +: ANGLE_W]),
            .update_angle(update_angle[i]), .abort_angle(abort_angle[i]),
            .pend(pend[i]), .rd_mux(ch_rd[i])
        );
    end
    always_comb begin
        ch_or = '0;
        hi_or = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            ch_or |= ch_rd[n];
            hi_or |= sel[n] ? current_angle[ANGLE_W*n+8 +: 4] : 4'd0;
        end
    end
    assign rd_next = !mapped ? 8'h00 :
                     in_ch ? ch_or :
                     address == ADDR_W'(ID_A) ? VERSION :
                     address == ADDR_W'(IRQ_EN_A) ? 8'(irq_en) :
                     address == ADDR_W'(IRQ_PEND_A) ? 8'(pend[EW-1:0]) :
                     address == ADDR_W'(CURR_HI_A) ? {|(angle_done & last_sel), 3'b0, shadow_hi} : 8'h00;
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            {rd_data, rd_valid, addr_err, irq, irq_en, shadow_hi, last_sel} <= '0;
        end else begin
            rd_valid <= read_en;
            addr_err <= (read_en || write_en) && !mapped;
            if (read_en) rd_data <= rd_next;
            if (curr_rd) begin
                shadow_hi <= hi_or;
                last_sel <= sel;
            end
            if (write_en && address == ADDR_W'(IRQ_EN_A)) irq_en <= wr_data[EW-1:0];
            irq <= |(pend[EW-1:0] & irq_en);
        end
    end
endmodule
